// File: rtl/mips_pipe_pkg.sv
// Shared constants for the 5-stage MIPS pipeline: datapath widths, the zero
// register index, control-bundle bit positions and the bubble control value.
package mips_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // Bit positions inside the opaque EX/MEM/WB control bundle.
    localparam int CTRL_ALU_SRC   = 0;
    localparam int CTRL_ALU_OP_LO = 1;
    localparam int CTRL_ALU_OP_HI = 3;
    localparam int CTRL_REG_DST   = 4;
    localparam int CTRL_MEM_WRITE = 5;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_BRANCH    = 7;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection between the instruction in ID and
// a load sitting in EX. Also used by the forwarding unit.
module hazard_detect #(
    parameter int REG_AW = mips_pipe_pkg::REG_AW
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              flush,
    output logic              hz,
    output logic              id_stall
);
    import mips_pipe_pkg::*;

    logic dest_live;
    logic src_match;

    // A load into $zero can never create a dependency.
    assign dest_live = (ex_dest != REG_AW'(REG_ZERO));
    assign src_match = (ex_dest == id_rs) || (ex_dest == id_rt);

    assign hz       = id_valid & ex_valid & ex_mem_read & dest_live & src_match;
    assign id_stall = hz & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall and flush.
// Optional macro ID_EX_WB_BYPASS_EN merges same-edge writebacks into operands.
module id_ex_stage #(
    parameter int DATA_W = mips_pipe_pkg::DATA_W,
    parameter int REG_AW = mips_pipe_pkg::REG_AW,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
    input  logic              reset,
    input  logic              clk2,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic              id_stall
);
    import mips_pipe_pkg::*;

    logic              valid_reg,     valid_next;
    logic [REG_AW-1:0] rs_reg,        rs_next;
    logic [REG_AW-1:0] rt_reg,        rt_next;
    logic [REG_AW-1:0] dest_reg,      dest_next;
    logic [DATA_W-1:0] op_a_reg,      op_a_next;
    logic [DATA_W-1:0] op_b_reg,      op_b_next;
    logic [DATA_W-1:0] imm_reg,       imm_next;
    logic [CTRL_W-1:0] ctrl_reg,      ctrl_next;
    logic              mem_read_reg,  mem_read_next;
    logic              reg_write_reg, reg_write_next;

    logic hz;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (valid_reg),
        .ex_mem_read (mem_read_reg),
        .ex_dest     (dest_reg),
        .flush       (flush),
        .hz          (hz),
        .id_stall    (id_stall)
    );

    logic [DATA_W-1:0] cap_op_a;
    logic [DATA_W-1:0] cap_op_b;
    logic [DATA_W-1:0] hold_op_a;
    logic [DATA_W-1:0] hold_op_b;

`ifdef ID_EX_WB_BYPASS_EN
    logic wb_live;
    assign wb_live = wb_reg_write && (wb_dest != REG_AW'(REG_ZERO));

    // The register file writes on the same edge we capture, so its read port
    // still shows the old value; take the writeback data instead.
    assign cap_op_a  = (wb_live && (wb_dest == id_rs))  ? wb_data : id_rdata1;
    assign cap_op_b  = (wb_live && (wb_dest == id_rt))  ? wb_data : id_rdata2;
    assign hold_op_a = (wb_live && (wb_dest == rs_reg)) ? wb_data : op_a_reg;
    assign hold_op_b = (wb_live && (wb_dest == rt_reg)) ? wb_data : op_b_reg;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_dest, wb_data};

    assign cap_op_a  = id_rdata1;
    assign cap_op_b  = id_rdata2;
    assign hold_op_a = op_a_reg;
    assign hold_op_b = op_b_reg;
`endif

    always_comb begin
        valid_next     = valid_reg;
        rs_next        = rs_reg;
        rt_next        = rt_reg;
        dest_next      = dest_reg;
        op_a_next      = op_a_reg;
        op_b_next      = op_b_reg;
        imm_next       = imm_reg;
        ctrl_next      = ctrl_reg;
        mem_read_next  = mem_read_reg;
        reg_write_next = reg_write_reg;

        // Flush and bubble both empty the stage; data is zeroed for clean traces.
        if (flush || (!ex_hold && hz)) begin
            valid_next     = 1'b0;
            rs_next        = '0;
            rt_next        = '0;
            dest_next      = '0;
            op_a_next      = '0;
            op_b_next      = '0;
            imm_next       = '0;
            ctrl_next      = CTRL_W'(CTRL_NOP);
            mem_read_next  = 1'b0;
            reg_write_next = 1'b0;
        end else if (ex_hold) begin
            op_a_next = hold_op_a;
            op_b_next = hold_op_b;
        end else begin
            valid_next     = id_valid;
            rs_next        = id_rs;
            rt_next        = id_rt;
            dest_next      = id_dest;
            op_a_next      = cap_op_a;
            op_b_next      = cap_op_b;
            imm_next       = id_imm;
            ctrl_next      = id_ctrl;
            mem_read_next  = id_valid & id_mem_read;
            reg_write_next = id_valid & id_reg_write;
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            valid_reg     <= 1'b0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            dest_reg      <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            imm_reg       <= '0;
            ctrl_reg      <= '0;
            mem_read_reg  <= 1'b0;
            reg_write_reg <= 1'b0;
        end else begin
            valid_reg     <= valid_next;
            rs_reg        <= rs_next;
            rt_reg        <= rt_next;
            dest_reg      <= dest_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
            imm_reg       <= imm_next;
            ctrl_reg      <= ctrl_next;
            mem_read_reg  <= mem_read_next;
            reg_write_reg <= reg_write_next;
        end
    end

    assign ex_valid     = valid_reg;
    assign ex_rs        = rs_reg;
    assign ex_rt        = rt_reg;
    assign ex_dest      = dest_reg;
    assign ex_op_a      = op_a_reg;
    assign ex_op_b      = op_b_reg;
    assign ex_imm       = imm_reg;
    assign ex_ctrl      = ctrl_reg;
    assign ex_mem_read  = mem_read_reg;
    assign ex_reg_write = reg_write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow
// ID_EX_WB_BYPASS_EN when it is defined.
module tb_id_ex_stage;

    logic        reset;
    logic        clk2;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [7:0]  id_ctrl;
    logic        id_mem_read, id_reg_write;
    logic        ex_hold, flush;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [31:0] ex_op_a, ex_op_b, ex_imm;
    logic [7:0]  ex_ctrl;
    logic        ex_mem_read, ex_reg_write;
    logic        id_stall;

    int checks = 0;
    int errors = 0;

`ifdef ID_EX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    id_ex_stage dut (
        .reset        (reset),
        .clk2         (clk2),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .id_mem_read  (id_mem_read),
        .id_reg_write (id_reg_write),
        .ex_hold      (ex_hold),
        .flush        (flush),
        .wb_reg_write (wb_reg_write),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dest      (ex_dest),
        .ex_op_a      (ex_op_a),
        .ex_op_b      (ex_op_b),
        .ex_imm       (ex_imm),
        .ex_ctrl      (ex_ctrl),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .id_stall     (id_stall)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
        $display("check %-18s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] dest, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [7:0] ctrl, input logic mr, input logic rw);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_dest      = dest;
        id_rdata1    = d1;
        id_rdata2    = d2;
        id_imm       = 32'h0000_0099;
        id_ctrl      = ctrl;
        id_mem_read  = mr;
        id_reg_write = rw;
    endtask

    initial begin
        // Reset held with random inputs
        reset        = 1'b0;
        drive_id($urandom_range(1), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
                 8'($urandom), 1'b1, 1'b1);
        ex_hold      = 1'b0;
        flush        = 1'b0;
        wb_reg_write = 1'b1;
        wb_dest      = 5'($urandom);
        wb_data      = $urandom;
        step();
        step();
        check("rst_valid",    32'(ex_valid), 32'd0);
        check("rst_op_a",     ex_op_a, 32'd0);
        check("rst_ctrl",     32'(ex_ctrl), 32'd0);
        check("rst_mem_read", 32'(ex_mem_read), 32'd0);
        check("rst_stall",    32'(id_stall), 32'd0);

        // Release reset, simple capture
        reset        = 1'b1;
        wb_reg_write = 1'b0;
        wb_dest      = 5'd0;
        wb_data      = 32'd0;
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 8'h21, 1'b0, 1'b1);
        step();
        check("cap_op_a",  ex_op_a, 32'h1234);
        check("cap_op_b",  ex_op_b, 32'h5678);
        check("cap_valid", 32'(ex_valid), 32'd1);
        check("cap_dest",  32'(ex_dest), 32'd3);
        check("cap_imm",   ex_imm, 32'h99);

        // Load-use: load into $8, then consumer of $8
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 8'h40, 1'b1, 1'b1);
        step();
        check("ld_mem_read", 32'(ex_mem_read), 32'd1);
        drive_id(1'b1, 5'd8, 5'd9, 5'd10, 32'hAAAA, 32'hBBBB, 8'h11, 1'b0, 1'b1);
        #1;
        check("lu_stall", 32'(id_stall), 32'd1);
        step();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_ctrl",  32'(ex_ctrl), 32'd0);
        check("lu_stall_drop",   32'(id_stall), 32'd0);
        step();
        check("lu_cap_valid", 32'(ex_valid), 32'd1);
        check("lu_cap_rs",    32'(ex_rs), 32'd8);
        check("lu_cap_op_a",  ex_op_a, 32'hAAAA);
        check("lu_no_stall",  32'(id_stall), 32'd0);

        // Load into $0 with consumer of $0: no stall; dest 0 captured as-is
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 8'h40, 1'b1, 1'b1);
        step();
        check("z_dest",      32'(ex_dest), 32'd0);
        check("z_reg_write", 32'(ex_reg_write), 32'd1);
        drive_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 8'h11, 1'b0, 1'b1);
        #1;
        check("z_no_stall", 32'(id_stall), 32'd0);
        step();
        check("z_cap_valid", 32'(ex_valid), 32'd1);

        // Back-to-back loads into $8
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 8'h40, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd8, 5'd2, 5'd8, 32'h3, 32'h4, 8'h40, 1'b1, 1'b1);
        #1;
        check("bb_stall1", 32'(id_stall), 32'd1);
        step();
        check("bb_bubble", 32'(ex_valid), 32'd0);
        step();
        check("bb_cap_mem_read", 32'(ex_mem_read), 32'd1);
        check("bb_cap_op_a",     ex_op_a, 32'h3);
        check("bb_stall2",       32'(id_stall), 32'd1);

        // Flush overrides hold and hazard
        flush   = 1'b1;
        ex_hold = 1'b1;
        #1;
        check("fl_stall", 32'(id_stall), 32'd0);
        step();
        check("fl_valid",    32'(ex_valid), 32'd0);
        check("fl_ctrl",     32'(ex_ctrl), 32'd0);
        check("fl_mem_read", 32'(ex_mem_read), 32'd0);
        check("fl_op_a",     ex_op_a, 32'd0);
        flush   = 1'b0;
        ex_hold = 1'b0;

        // Hold for 3 cycles while ID changes
        drive_id(1'b1, 5'd3, 5'd4, 5'd10, 32'h11, 32'h22, 8'h5A, 1'b0, 1'b1);
        step();
        check("h_cap_op_a", ex_op_a, 32'h11);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 5'd7, 5'd12, 5'(20 + i), 32'(32'h100 + i), 32'h200, 8'hC3, 1'b0, 1'b0);
            step();
            check("h_op_a", ex_op_a, 32'h11);
            check("h_ctrl", 32'(ex_ctrl), 32'h5A);
            check("h_dest", 32'(ex_dest), 32'd10);
        end
        ex_hold = 1'b0;
        step();
        check("h_rel_op_a", ex_op_a, 32'h102);
        check("h_rel_ctrl", 32'(ex_ctrl), 32'hC3);
        check("h_rel_rw",   32'(ex_reg_write), 32'd0);

        // Writeback bypass on capture
        drive_id(1'b1, 5'd6, 5'd5, 5'd11, 32'h10, 32'h0, 8'h01, 1'b0, 1'b1);
        wb_reg_write = 1'b1;
        wb_dest      = 5'd5;
        wb_data      = 32'hDEADBEEF;
        step();
        check("bp_op_b", ex_op_b, BYP ? 32'hDEADBEEF : 32'h0);
        check("bp_op_a", ex_op_a, 32'h10);

        // Writeback refresh during hold
        ex_hold = 1'b1;
        wb_dest = 5'd6;
        wb_data = 32'h77;
        step();
        check("bp_hold_op_a", ex_op_a, BYP ? 32'h77 : 32'h10);
        check("bp_hold_op_b", ex_op_b, BYP ? 32'hDEADBEEF : 32'h0);
        ex_hold = 1'b0;

        // Writeback to $0 never bypasses
        drive_id(1'b1, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 8'h01, 1'b0, 1'b1);
        wb_dest = 5'd0;
        wb_data = 32'hFFFF;
        step();
        check("bp_zero_op_a", ex_op_a, 32'h0);
        check("bp_zero_op_b", ex_op_b, 32'h0);
        wb_reg_write = 1'b0;

        // Invalid ID slot clears write/read enables
        drive_id(1'b0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 8'h0F, 1'b1, 1'b1);
        step();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_rw",    32'(ex_reg_write), 32'd0);
        check("inv_mr",    32'(ex_mem_read), 32'd0);

        // Asynchronous reset in the middle of a hold
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 8'h33, 1'b0, 1'b1);
        step();
        ex_hold = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_op_a",  ex_op_a, 32'd0);
        check("arst_ctrl",  32'(ex_ctrl), 32'd0);
        reset   = 1'b1;
        ex_hold = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Captures the operands and decode fields produced in ID, including the two register-file read ports, and presents them to EX.
- Detects load-use hazards and inserts bubbles, handling stall and flush.
- Optionally bypasses a same-cycle writeback into the captured operands.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register index width
- CTRL_W, 8, opaque EX/MEM/WB control bundle width

Ports:
- reset  in  1  asynchronous, active-low
- clk2  in  1  stage clock; all state updates on rising edge
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source register indices
- id_dest  in  REG_AW  destination register index
- id_rdata1, id_rdata2  in  DATA_W  register-file read data; register 0 already reads as 0
- id_imm  in  DATA_W  extended immediate
- id_ctrl  in  CTRL_W  control bundle
- id_mem_read  in  1  instruction is a load
- id_reg_write  in  1  instruction writes a register
- ex_hold  in  1  downstream stall; freeze this stage
- flush  in  1  branch/jump squash
- wb_reg_write  in  1  writeback enable, same signal that drives the register file
- wb_dest  in  REG_AW  writeback register index
- wb_data  in  DATA_W  writeback data
- ex_valid  out  1
- ex_rs, ex_rt, ex_dest  out  REG_AW
- ex_op_a, ex_op_b, ex_imm  out  DATA_W
- ex_ctrl  out  CTRL_W
- ex_mem_read, ex_reg_write  out  1
- id_stall  out  1  freeze PC and IF/ID (combinational)

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0 except id_stall, which is combinational and therefore also 0 because ex_valid=0.
- Load-use hazard (combinational): hz = id_valid & ex_valid & ex_mem_read & (ex_dest!=0) & (ex_dest==id_rs | ex_dest==id_rt).
- id_stall = hz & ~flush.
- Per rising clk2, first matching rule wins:
  1. flush=1: ex_valid, ex_reg_write, ex_mem_read, ex_ctrl <= 0. Data fields are don't-care; the implementation drives them to 0. Flush overrides ex_hold.
  2. ex_hold=1: all registers hold. Exception: operand refresh, see Optional Feature.
  3. hz=1: bubble. Control fields are cleared exactly as for flush.
  4. Otherwise: capture every id_* field. ex_valid <= id_valid. When id_valid=0, ex_reg_write and ex_mem_read <= 0.
- Latency: 1 cycle ID->EX.
- Exactly one bubble per load-use: after the bubble ex_mem_read=0, so hz deasserts on its own.
- Back-to-back loads into the same register each produce their own single bubble.
- id_dest=0 with id_reg_write=1: captured as-is; the register file ignores the write.
- No internal state survives reset. Reset mid-hold or mid-bubble returns to the empty stage.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- With the macro defined:
  - On capture, if wb_reg_write & wb_dest!=0 & wb_dest==id_rs, ex_op_a <= wb_data; same rule for id_rt -> ex_op_b.
  - This covers the register file's write and read landing on the same edge.
  - During ex_hold, a held operand whose ex_rs or ex_rt matches a qualifying writeback is refreshed with wb_data, so held operands never go stale.
- Without the macro: operands are captured raw from id_rdata1/2 and are never refreshed. Upstream forwarding must cover the WB case.

Decomposition:
- Shared package mips_pipe_pkg:
  - DATA_W, REG_AW, CTRL_W
  - REG_ZERO constant
  - ctrl bundle bit positions
  - bubble/NOP control constant (all zero)
- Natural sub-module: hazard_detect, holding the combinational hz/id_stall logic. It is reused by the later forwarding unit.

Test Plan:
- Reset: hold reset=0 with random inputs -> all ex_* = 0 and id_stall=0. Release, then capture id_rdata1=0x1234, id_valid=1 -> ex_op_a=0x1234 after 1 edge.
- Load-use:
  - Cycle n: ex holds a load with ex_dest=8. ID has id_rs=8 -> id_stall=1.
  - Next edge: ex_valid=0.
  - Following edge: instruction captured, id_stall=0.
  - Only one bubble total.
- ex_dest=0 load with id_rs=0 -> no stall.
- Flush with ex_hold=1 and hz=1 all asserted -> ex_valid=0, ex_ctrl=0.
- ex_hold: assert for 3 cycles while id_* changes -> ex_* unchanged. Release -> new values captured.
- With ID_EX_WB_BYPASS_EN:
  - wb_dest=5, wb_data=0xDEADBEEF, id_rt=5, id_rdata2=0 -> ex_op_b=0xDEADBEEF.
  - During hold, wb writes ex_rs's register with 0x77 -> ex_op_a=0x77.
  - wb_dest=0 -> no bypass.
- Without the macro, the same bypass stimulus leaves ex_op_b=0.
